// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: owner encoding, memory size
// and the word-address range check.
package mem_arbiter_pkg;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int MEM_WORDS_DEF = 6144;
  localparam int WORD_AW       = 30;

  // Byte address -> true when its word index lies inside the backing memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] words);
    logic [WORD_AW-1:0] word_idx;
    word_idx = addr[31:2];
    return (32'(word_idx) < words);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the single-port word memory.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic        mem_ren;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  // slave: the arbiter's view (takes requests, drives the memory)
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           mem_addr, mem_ren, mem_wdata, mem_wmask
  );

  // master: the core ports plus the memory array
  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           mem_addr, mem_ren, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way request arbiter, one-hot grant. Bit 0 is the fetch port, bit 1 the data port.
module arb_rr2
  import mem_arbiter_pkg::*;
#(
  parameter bit RR_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_e last_q;

  // On a tie, round-robin hands the grant to whoever did not get it last;
  // fixed priority always favours the data port.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (RR_MODE && (last_q == OWNER_DATA)) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_q <= OWNER_FETCH;
    end else if (|gnt) begin
      last_q <= gnt[1] ? OWNER_DATA : OWNER_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port, 1-cycle-latency word memory between the fetch and data ports;
// blocks out-of-range accesses and returns one response per accepted access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int RR_MODE   = 1
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        any_gnt;
  owner_e      sel_owner;
  logic [31:0] sel_addr;
  logic [3:0]  sel_wmask;
  logic        sel_oor;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        pend_valid;
  owner_e      pend_owner;
  logic        pend_err;
  logic        pend_wr;

  logic        i_own;
  logic        d_own;
  logic        rd_ok;

  // Requests are masked during reset so nothing is granted or issued.
  assign req = resetn ? {bus.d_req, bus.i_req} : 2'b00;

  arb_rr2 #(
    .RR_MODE (RR_MODE != 0)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .gnt    (gnt)
  );

  assign bus.i_gnt = gnt[0];
  assign bus.d_gnt = gnt[1];

  assign any_gnt   = |gnt;
  assign sel_owner = gnt[1] ? OWNER_DATA : OWNER_FETCH;
  assign sel_addr  = gnt[1] ? bus.d_addr : bus.i_addr;
  assign sel_wmask = gnt[1] ? bus.d_wmask : 4'b0000;
  assign sel_oor   = !addr_in_range(sel_addr, 32'(MEM_WORDS));

  always_comb begin
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_ren   = 1'b0;
    bus.mem_wmask = 4'b0000;
    if (any_gnt) begin
      bus.mem_addr = sel_addr;
      if (!sel_oor) begin
        if (|sel_wmask) begin
          bus.mem_wmask = sel_wmask;
          bus.mem_wdata = bus.d_wdata;
        end else begin
          bus.mem_ren = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_owner <= OWNER_FETCH;
      pend_err   <= 1'b0;
      pend_wr    <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      pend_valid <= any_gnt;
      addr_q     <= bus.mem_addr;
      wdata_q    <= bus.mem_wdata;
      if (any_gnt) begin
        pend_owner <= sel_owner;
        pend_err   <= sel_oor;
        pend_wr    <= |sel_wmask;
      end
    end
  end

  // Memory data is only forwarded for an in-range read; stores and blocked
  // accesses answer with zero data.
  assign i_own = pend_valid && (pend_owner == OWNER_FETCH);
  assign d_own = pend_valid && (pend_owner == OWNER_DATA);
  assign rd_ok = !pend_err && !pend_wr;

  assign bus.i_rvalid = i_own;
  assign bus.i_err    = i_own && pend_err;
  assign bus.i_rdata  = (i_own && rd_ok) ? bus.mem_rdata : 32'h0;

  assign bus.d_rvalid = d_own;
  assign bus.d_err    = d_own && pend_err;
  assign bus.d_rdata  = (d_own && rd_ok) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter and its memory.
module tb_mem_arbiter;

  localparam int MEM_WORDS = 6144;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] mem1    [MEM_WORDS];
  logic [31:0] mem0    [MEM_WORDS];

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus0 ();

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .RR_MODE(1)) dut_rr (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .RR_MODE(0)) dut_fp (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_init(input int k);
    return {8'(4*k + 116), 8'(4*k + 115), 8'(4*k + 114), 8'(4*k + 113)};
  endfunction

  // Memory models: read data appears the cycle after mem_ren, byte-masked writes.
  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem1[k] = word_init(k);
    bus1.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (bus1.mem_ren && (bus1.mem_addr[31:2] < MEM_WORDS))
        bus1.mem_rdata <= mem1[int'(bus1.mem_addr[31:2])];
      if (bus1.mem_addr[31:2] < MEM_WORDS)
        for (int b = 0; b < 4; b++)
          if (bus1.mem_wmask[b]) mem1[int'(bus1.mem_addr[31:2])][8*b +: 8] = bus1.mem_wdata[8*b +: 8];
    end
  end

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem0[k] = word_init(k);
    bus0.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (bus0.mem_ren && (bus0.mem_addr[31:2] < MEM_WORDS))
        bus0.mem_rdata <= mem0[int'(bus0.mem_addr[31:2])];
      if (bus0.mem_addr[31:2] < MEM_WORDS)
        for (int b = 0; b < 4; b++)
          if (bus0.mem_wmask[b]) mem0[int'(bus0.mem_addr[31:2])][8*b +: 8] = bus0.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wmask);
    if (addr[31:2] < MEM_WORDS)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) ref_mem[int'(addr[31:2])][8*b +: 8] = wdata[8*b +: 8];
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel <= 6) return {20'h0, 10'(96 + $urandom_range(0, 31)), 2'($urandom_range(0, 3))};
    if (sel == 7) return 32'h0000_5FFC;
    if (sel == 8) return 32'h0000_6000 + 32'($urandom_range(0, 255));
    return $urandom();
  endfunction

  // Randomized-run model state
  logic        last_data, pv, po, perr;
  logic [31:0] pdata;
  logic        i_hold, d_hold, gi, gd, inr;
  logic [31:0] a;
  logic [3:0]  wm;

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) ref_mem[k] = word_init(k);
    resetn = 1'b0;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h190;
    bus1.d_req = 1'b1; bus1.d_addr = 32'h194; bus1.d_wdata = 32'h0; bus1.d_wmask = 4'h0;
    bus0.i_req = 1'b0; bus0.i_addr = 32'h0;
    bus0.d_req = 1'b0; bus0.d_addr = 32'h0; bus0.d_wdata = 32'h0; bus0.d_wmask = 4'h0;

    // Reset held with both requests up
    repeat (3) begin
      smp();
      chk("rst_i_gnt", bus1.i_gnt, 0);
      chk("rst_d_gnt", bus1.d_gnt, 0);
      chk("rst_i_rvalid", bus1.i_rvalid, 0);
      chk("rst_d_rvalid", bus1.d_rvalid, 0);
      chk("rst_mem_ren", bus1.mem_ren, 0);
      chk("rst_mem_wmask", bus1.mem_wmask, 0);
      nxt();
    end
    resetn = 1'b1; bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    smp();
    chk("rel_i_rvalid", bus1.i_rvalid, 0);
    chk("rel_d_rvalid", bus1.d_rvalid, 0);
    nxt();

    // Fetch only
    bus1.i_req = 1'b1; bus1.i_addr = 32'h190;
    smp();
    chk("f_i_gnt", bus1.i_gnt, 1);
    chk("f_d_gnt", bus1.d_gnt, 0);
    chk("f_mem_ren", bus1.mem_ren, 1);
    chk("f_mem_addr", bus1.mem_addr, 32'h190);
    chk("f_mem_wmask", bus1.mem_wmask, 0);
    nxt();
    bus1.i_req = 1'b0;
    smp();
    chk("f_i_rvalid", bus1.i_rvalid, 1);
    chk("f_i_rdata", bus1.i_rdata, 32'h0403_0201);
    chk("f_i_err", bus1.i_err, 0);
    chk("f_d_rvalid", bus1.d_rvalid, 0);
    nxt();

    // Contention: round-robin on dut_rr, fixed priority on dut_fp
    bus1.i_req = 1'b1; bus1.i_addr = 32'h190; bus1.d_req = 1'b1; bus1.d_addr = 32'h198; bus1.d_wmask = 4'h0;
    bus0.i_req = 1'b1; bus0.i_addr = 32'h190; bus0.d_req = 1'b1; bus0.d_addr = 32'h198; bus0.d_wmask = 4'h0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("rr_d_gnt", bus1.d_gnt, (k % 2 == 0));
      chk("rr_i_gnt", bus1.i_gnt, (k % 2 == 1));
      chk("fp_d_gnt", bus0.d_gnt, 1);
      chk("fp_i_gnt", bus0.i_gnt, 0);
      if (k > 0) begin
        chk("rr_d_rvalid", bus1.d_rvalid, (k % 2 == 1));
        chk("rr_i_rvalid", bus1.i_rvalid, (k % 2 == 0));
        chk("rr_rdata", (k % 2 == 1) ? bus1.d_rdata : bus1.i_rdata,
            (k % 2 == 1) ? 32'h0C0B_0A09 : 32'h0403_0201);
        chk("fp_d_rvalid", bus0.d_rvalid, 1);
        chk("fp_d_rdata", bus0.d_rdata, 32'h0C0B_0A09);
        chk("fp_i_rvalid", bus0.i_rvalid, 0);
      end
      nxt();
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0; bus0.i_req = 1'b0; bus0.d_req = 1'b0;
    smp();
    chk("rr_last_i_rvalid", bus1.i_rvalid, 1);
    chk("rr_last_i_rdata", bus1.i_rdata, 32'h0403_0201);
    chk("rr_last_d_rvalid", bus1.d_rvalid, 0);
    chk("fp_last_d_rvalid", bus0.d_rvalid, 1);
    nxt();

    // Store then load, back to back
    bus1.d_req = 1'b1; bus1.d_addr = 32'h194; bus1.d_wdata = 32'h0000_AB00; bus1.d_wmask = 4'b0010;
    smp();
    chk("st_d_gnt", bus1.d_gnt, 1);
    chk("st_mem_wmask", bus1.mem_wmask, 4'b0010);
    chk("st_mem_ren", bus1.mem_ren, 0);
    chk("st_mem_addr", bus1.mem_addr, 32'h194);
    chk("st_mem_wdata", bus1.mem_wdata, 32'h0000_AB00);
    ref_write(32'h194, 32'h0000_AB00, 4'b0010);
    nxt();
    bus1.d_wmask = 4'b0000;
    smp();
    chk("st_d_rvalid", bus1.d_rvalid, 1);
    chk("st_d_rdata", bus1.d_rdata, 0);
    chk("st_d_err", bus1.d_err, 0);
    chk("ld_d_gnt", bus1.d_gnt, 1);
    chk("ld_mem_ren", bus1.mem_ren, 1);
    nxt();
    bus1.d_req = 1'b0;
    smp();
    chk("ld_d_rvalid", bus1.d_rvalid, 1);
    chk("ld_d_rdata", bus1.d_rdata, 32'h0807_AB05);
    chk("ld_d_err", bus1.d_err, 0);
    nxt();

    // Out of range on both ports
    bus1.d_req = 1'b1; bus1.d_addr = 32'h6000; bus1.d_wdata = 32'hFFFF_FFFF; bus1.d_wmask = 4'hF;
    smp();
    chk("oor_d_gnt", bus1.d_gnt, 1);
    chk("oor_mem_wmask", bus1.mem_wmask, 0);
    chk("oor_mem_ren", bus1.mem_ren, 0);
    nxt();
    bus1.d_req = 1'b0; bus1.d_wmask = 4'h0; bus1.i_req = 1'b1; bus1.i_addr = 32'h6000;
    smp();
    chk("oor_d_rvalid", bus1.d_rvalid, 1);
    chk("oor_d_err", bus1.d_err, 1);
    chk("oor_d_rdata", bus1.d_rdata, 0);
    chk("oor_i_gnt", bus1.i_gnt, 1);
    chk("oor_i_mem_ren", bus1.mem_ren, 0);
    nxt();
    bus1.i_req = 1'b0;
    smp();
    chk("oor_i_rvalid", bus1.i_rvalid, 1);
    chk("oor_i_err", bus1.i_err, 1);
    chk("oor_i_rdata", bus1.i_rdata, 0);
    nxt();

    // Reset right after a granted load
    bus1.d_req = 1'b1; bus1.d_addr = 32'h190; bus1.d_wmask = 4'h0;
    smp();
    chk("rmid_d_gnt", bus1.d_gnt, 1);
    resetn = 1'b0; bus1.d_req = 1'b0;
    nxt();
    smp();
    chk("rmid_d_rvalid_rst", bus1.d_rvalid, 0);
    nxt();
    resetn = 1'b1;
    smp();
    chk("rmid_d_rvalid_rel", bus1.d_rvalid, 0);
    chk("rmid_i_rvalid_rel", bus1.i_rvalid, 0);
    nxt();

    // Randomized traffic against the transaction model
    last_data = 1'b0; pv = 1'b0; po = 1'b0; perr = 1'b0; pdata = 32'h0;
    i_hold = 1'b0; d_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!i_hold) begin
        bus1.i_req  = 1'($urandom_range(0, 1));
        bus1.i_addr = rand_addr();
      end
      if (!d_hold) begin
        bus1.d_req   = 1'($urandom_range(0, 1));
        bus1.d_addr  = rand_addr();
        bus1.d_wdata = $urandom();
        bus1.d_wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      gi = bus1.i_req && (!bus1.d_req || last_data);
      gd = bus1.d_req && !gi;
      smp();
      chk("r_i_rvalid", bus1.i_rvalid, pv && !po);
      chk("r_d_rvalid", bus1.d_rvalid, pv && po);
      chk("r_i_rdata", bus1.i_rdata, (pv && !po) ? pdata : 32'h0);
      chk("r_d_rdata", bus1.d_rdata, (pv && po) ? pdata : 32'h0);
      chk("r_i_err", bus1.i_err, pv && !po && perr);
      chk("r_d_err", bus1.d_err, pv && po && perr);
      chk("r_i_gnt", bus1.i_gnt, gi);
      chk("r_d_gnt", bus1.d_gnt, gd);
      if (gi || gd) begin
        a   = gd ? bus1.d_addr : bus1.i_addr;
        wm  = gd ? bus1.d_wmask : 4'h0;
        inr = (a[31:2] < MEM_WORDS);
        chk("r_mem_ren", bus1.mem_ren, inr && (wm == 4'h0));
        chk("r_mem_wmask", bus1.mem_wmask, inr ? wm : 4'h0);
        if (inr) chk("r_mem_addr", bus1.mem_addr, a);
        if (inr && (wm != 4'h0)) chk("r_mem_wdata", bus1.mem_wdata, bus1.d_wdata);
        pdata = (inr && (wm == 4'h0)) ? ref_mem[int'(a[31:2])] : 32'h0;
        perr  = !inr;
        if (inr && (wm != 4'h0)) ref_write(a, bus1.d_wdata, wm);
        pv = 1'b1; po = gd; last_data = gd;
      end else begin
        chk("r_idle_mem_ren", bus1.mem_ren, 0);
        chk("r_idle_mem_wmask", bus1.mem_wmask, 0);
        pv = 1'b0;
      end
      i_hold = bus1.i_req && !gi;
      d_hold = bus1.d_req && !gd;
      nxt();
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    smp();
    chk("r_end_i_rvalid", bus1.i_rvalid, pv && !po);
    chk("r_end_d_rvalid", bus1.d_rvalid, pv && po);
    chk("r_end_rdata", po ? bus1.d_rdata : bus1.i_rdata, pv ? pdata : 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
